// File: rtl/io_oa_of.sv
// Slow-out output assembly: serially loads a format code into OF and a digit into OA
// once per drum word, then offers the character to the device over a valid/ack handshake.
module io_oa_of #(
  parameter int WORD_BITS = 29,
  parameter int FMT_BITS  = 3,
  parameter int DIG_BITS  = 4
) (
  input  logic                CLOCK,
  input  logic                rst,
  input  logic                T0,
  input  logic                SLOW_OUT,
  input  logic                FMT,
  input  logic                MZ,
  input  logic                CHAR_ACK,
  output logic                OA1,
  output logic                OA4,
  output logic [DIG_BITS-1:0] OA,
  output logic                OF1,
  output logic                OF2,
  output logic                OF3,
  output logic                DIGIT_OF,
  output logic                CR_TAB_OF,
  output logic                WAIT_OF,
  output logic                CHAR_VALID,
  output logic                CHAR_IS_FMT,
  output logic                OUT_DONE
);

  localparam int CW = $clog2(WORD_BITS);
  localparam logic [FMT_BITS-1:0] C_DIGIT = FMT_BITS'(0);
  localparam logic [FMT_BITS-1:0] C_STOP  = FMT_BITS'(1);
  localparam logic [FMT_BITS-1:0] C_CR    = FMT_BITS'(2);
  localparam logic [FMT_BITS-1:0] C_TAB   = FMT_BITS'(6);
  localparam logic [FMT_BITS-1:0] C_WAIT  = FMT_BITS'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FMT,
    S_LOAD_DIG,
    S_OFFER,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [FMT_BITS-1:0] of_q, of_d;
  logic [DIG_BITS-1:0] oa_q, oa_d;
  logic                seen_t0_q, seen_t0_d;
  logic                char_valid_q, char_valid_d;
  logic                char_is_fmt_q, char_is_fmt_d;
  logic                out_done_q, out_done_d;
  logic                decode_en;

  always_comb begin
    if (T0) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(WORD_BITS - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    of_d          = of_q;
    oa_d          = oa_q;
    seen_t0_d     = seen_t0_q;
    char_valid_d  = char_valid_q;
    char_is_fmt_d = char_is_fmt_q;
    out_done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        char_valid_d = 1'b0;
        if (T0 && SLOW_OUT) begin
          state_d = S_LOAD_FMT;
          of_d    = '0;
          oa_d    = '0;
        end
      end

      S_LOAD_FMT: begin
        // A word marker mid-shift throws away the partial code and starts again.
        if (T0) begin
          of_d = '0;
        end else begin
          for (int i = 0; i < FMT_BITS; i++) begin
            if (cnt_d == CW'(i + 1)) begin
              of_d[i] = FMT;
            end
          end
          if (cnt_d == CW'(FMT_BITS)) begin
            if (of_d == C_STOP) begin
              state_d    = S_DONE;
              out_done_d = 1'b1;
            end else if (of_d == C_DIGIT || of_d == C_WAIT) begin
              state_d   = S_LOAD_DIG;
              seen_t0_d = 1'b0;
            end else begin
              state_d       = S_OFFER;
              char_valid_d  = 1'b1;
              char_is_fmt_d = 1'b1;
            end
          end
        end
      end

      S_LOAD_DIG: begin
        // The digit comes from the word after the one that carried the code.
        if (T0) begin
          seen_t0_d = 1'b1;
          oa_d      = '0;
        end else if (seen_t0_q) begin
          for (int i = 0; i < DIG_BITS; i++) begin
            if (cnt_d == CW'(i + 1)) begin
              oa_d[i] = MZ;
            end
          end
          if (cnt_d == CW'(DIG_BITS + 1)) begin
            if (of_q == C_WAIT) begin
              state_d = S_NEXT;
            end else begin
              state_d       = S_OFFER;
              char_valid_d  = 1'b1;
              char_is_fmt_d = 1'b0;
            end
          end
        end
      end

      S_OFFER: begin
        if (CHAR_ACK) begin
          char_valid_d = 1'b0;
          state_d      = S_NEXT;
        end
      end

      S_NEXT: begin
        if (T0) begin
          state_d = S_LOAD_FMT;
          of_d    = '0;
          oa_d    = '0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        of_d    = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Losing SLOW_OUT overrides everything, including a pending ack or stop pulse.
    if (state_q != S_IDLE && !SLOW_OUT) begin
      state_d      = S_IDLE;
      char_valid_d = 1'b0;
      out_done_d   = 1'b0;
      of_d         = '0;
      oa_d         = '0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      of_q          <= '0;
      oa_q          <= '0;
      seen_t0_q     <= 1'b0;
      char_valid_q  <= 1'b0;
      char_is_fmt_q <= 1'b0;
      out_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      of_q          <= of_d;
      oa_q          <= oa_d;
      seen_t0_q     <= seen_t0_d;
      char_valid_q  <= char_valid_d;
      char_is_fmt_q <= char_is_fmt_d;
      out_done_q    <= out_done_d;
    end
  end

  assign decode_en   = (state_q != S_IDLE) && (state_q != S_LOAD_FMT);
  assign DIGIT_OF    = decode_en && (of_q == C_DIGIT);
  assign CR_TAB_OF   = decode_en && (of_q == C_CR || of_q == C_TAB);
  assign WAIT_OF     = decode_en && (of_q == C_WAIT);

  assign OA          = oa_q;
  assign OA1         = oa_q[0];
  assign OA4         = oa_q[DIG_BITS-1];
  assign OF1         = of_q[0];
  assign OF2         = of_q[1];
  assign OF3         = of_q[2];
  assign CHAR_VALID  = char_valid_q;
  assign CHAR_IS_FMT = char_is_fmt_q;
  assign OUT_DONE    = out_done_q;

endmodule

// File: tb/tb_io_oa_of.sv
// Bench for io_oa_of: per-code vector table, hand-written corner sequences, and
// randomized word-level runs checked against a word-granular plan of offers and stops.
module tb_io_oa_of;

  localparam int WB = 29;
  localparam int NW = 60;
  localparam int NG = NW * WB;

  logic       CLOCK = 1'b0;
  logic       rst = 1'b1;
  logic       T0 = 1'b0, SLOW_OUT = 1'b0, FMT = 1'b0, MZ = 1'b0, CHAR_ACK = 1'b0;
  logic       OA1, OA4, OF1, OF2, OF3;
  logic [3:0] OA;
  logic       DIGIT_OF, CR_TAB_OF, WAIT_OF, CHAR_VALID, CHAR_IS_FMT, OUT_DONE;

  int n_cmp = 0;
  int n_err = 0;

  io_oa_of dut (
    .CLOCK(CLOCK), .rst(rst), .T0(T0), .SLOW_OUT(SLOW_OUT), .FMT(FMT), .MZ(MZ),
    .CHAR_ACK(CHAR_ACK), .OA1(OA1), .OA4(OA4), .OA(OA), .OF1(OF1), .OF2(OF2), .OF3(OF3),
    .DIGIT_OF(DIGIT_OF), .CR_TAB_OF(CR_TAB_OF), .WAIT_OF(WAIT_OF),
    .CHAR_VALID(CHAR_VALID), .CHAR_IS_FMT(CHAR_IS_FMT), .OUT_DONE(OUT_DONE)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Drive one bit time c of a word carrying format code `code` and digit `dig`.
  task automatic wc(input int c, input logic [2:0] code, input logic [3:0] dig, input logic ack);
    logic [2:0] fsh;
    logic [3:0] dsh;
    fsh = code;
    dsh = dig;
    T0  = (c == 0);
    FMT = 1'b0;
    MZ  = 1'b0;
    if (c >= 1 && c <= 3) begin
      fsh = code >> (c - 1);
      FMT = fsh[0];
    end
    if (c >= 1 && c <= 4) begin
      dsh = dig >> (c - 1);
      MZ = dsh[0];
    end
    CHAR_ACK = ack;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    SLOW_OUT = 1'b0;
    T0 = 1'b0; FMT = 1'b0; MZ = 1'b0; CHAR_ACK = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] obs_all();
    return {1'b0, OA, OF3, OF2, OF1, DIGIT_OF, CR_TAB_OF, WAIT_OF,
            CHAR_VALID, CHAR_IS_FMT, OUT_DONE, OA1, OA4};
  endfunction

  typedef struct {
    logic [2:0] code;
    logic [3:0] dig;
    logic       e_dig, e_crt, e_wait, e_done, e_fofr, e_dofr;
  } vec_t;

  vec_t tbl [8];

  // Word-level plan built by the reference model.
  logic [2:0] fmt_w   [NW];
  logic [3:0] dig_w   [NW];
  bit         ack_at  [NG];
  bit         exp_cv  [NG];
  bit         exp_done[NG];
  bit         st_flag [NG];
  logic [2:0] st_code [NG];
  bit         st_isf  [NG];
  bit         oa_chk  [NG];
  logic [3:0] oa_exp  [NG];
  int         w_end;

  // Walk the words: each fetch consumes one word (code), digit codes consume the next,
  // offers hold until the planned ack, and the next fetch is the word after that.
  task automatic plan(input bit fixed);
    logic [2:0] prog [3];
    logic [2:0] code;
    int w, n, s, ow, k, p, a;
    bit isf;
    logic [3:0] d;
    prog[0] = 3'b000; prog[1] = 3'b011; prog[2] = 3'b001;
    for (int g = 0; g < NG; g++) begin
      ack_at[g] = 0; exp_cv[g] = 0; exp_done[g] = 0; st_flag[g] = 0;
      st_code[g] = 3'b000; st_isf[g] = 0; oa_chk[g] = 0; oa_exp[g] = 4'h0;
    end
    for (int i = 0; i < NW; i++) begin
      fmt_w[i] = 3'($urandom_range(0, 7));
      dig_w[i] = 4'($urandom_range(0, 15));
    end
    if (fixed) dig_w[1] = 4'b1001;
    w = 0;
    n = 0;
    while (w + 4 <= NW && !(fixed && n >= 3)) begin
      code = fixed ? prog[n] : 3'($urandom_range(0, 7));
      n++;
      fmt_w[w] = code;
      if (code == 3'b001) begin
        exp_done[w*WB + 3] = 1;
        w = w + 1;
      end else if (code == 3'b111) begin
        oa_chk[(w+1)*WB + 5] = 1;
        oa_exp[(w+1)*WB + 5] = dig_w[w+1];
        w = w + 2;
      end else begin
        if (code == 3'b000) begin
          ow = w + 1; s = ow*WB + 5; isf = 0; d = dig_w[w+1];
          oa_chk[s] = 1; oa_exp[s] = d;
        end else begin
          ow = w; s = ow*WB + 3; isf = 1;
        end
        k = fixed ? 0 : $urandom_range(0, 2);
        if (k == 0) p = fixed ? (s % WB) + 1 : $urandom_range((s % WB) + 1, WB - 1);
        else        p = $urandom_range(0, WB - 1);
        a = (ow + k)*WB + p;
        ack_at[a] = 1;
        for (int g = s; g < a; g++) exp_cv[g] = 1;
        st_flag[s] = 1; st_code[s] = code; st_isf[s] = isf;
        w = ow + k + 1;
      end
    end
    w_end = w;
  endtask

  task automatic run_plan(input int id);
    int ncyc, w, c;
    logic [2:0] ec;
    do_reset();
    ncyc = (w_end < NW) ? (w_end + 1)*WB : NG;
    for (int g = 0; g < ncyc; g++) begin
      w = g / WB;
      c = g % WB;
      SLOW_OUT = (w < w_end);
      wc(c, fmt_w[w], dig_w[w], ack_at[g]);
      chk("run_valid_done", {14'h0, CHAR_VALID, OUT_DONE}, {14'h0, exp_cv[g], exp_done[g]});
      if (st_flag[g]) begin
        ec = st_code[g];
        chk("run_offer", {9'h0, CHAR_IS_FMT, OF3, OF2, OF1, DIGIT_OF, CR_TAB_OF, WAIT_OF},
            {9'h0, st_isf[g], ec, ec == 3'b000, ec == 3'b010 || ec == 3'b110, ec == 3'b111});
      end
      if (oa_chk[g]) begin
        chk("run_oa", {10'h0, OA, OA4, OA1}, {10'h0, oa_exp[g], oa_exp[g][3], oa_exp[g][0]});
      end
    end
    $display("run %0d: %0d words, %0d cycles", id, w_end, ncyc);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{3'b000, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{3'b010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{3'b011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{3'b101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{3'b110, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{3'b111, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    do_reset();
    chk("reset_state", obs_all(), 16'h0000);

    // One code per vector: fetch word, then the following word supplies the digit.
    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      do_reset();
      SLOW_OUT = 1'b1;
      for (int c = 0; c <= 3; c++) wc(c, v.code, 4'h0, 1'b0);
      chk("fmt_decode", {8'h0, DIGIT_OF, CR_TAB_OF, WAIT_OF, OUT_DONE, CHAR_VALID, OF3, OF2, OF1},
          {8'h0, v.e_dig, v.e_crt, v.e_wait, v.e_done, v.e_fofr, v.code});
      if (v.e_fofr) chk("fmt_is_fmt", {15'h0, CHAR_IS_FMT}, 16'h0001);
      wc(4, v.code, 4'h0, v.e_fofr);
      chk("after_count4", {14'h0, CHAR_VALID, OUT_DONE}, 16'h0000);
      for (int c = 5; c < WB; c++) wc(c, v.code, 4'h0, 1'b0);
      for (int c = 0; c <= 5; c++) wc(c, 3'b000, v.dig, 1'b0);
      chk("dig_offer", {15'h0, CHAR_VALID}, {15'h0, v.e_dofr});
      if (v.e_dig || v.e_wait)
        chk("dig_oa", {10'h0, OA, OA4, OA1}, {10'h0, v.dig, v.dig[3], v.dig[0]});
      if (v.e_dofr) begin
        chk("dig_is_fmt", {15'h0, CHAR_IS_FMT}, 16'h0000);
        wc(6, 3'b000, v.dig, 1'b1);
        chk("dig_ack", {15'h0, CHAR_VALID}, 16'h0000);
      end
      $display("vector %0d: code %b digit %b", i, v.code, v.dig);
    end

    // Reset while the digit is partially shifted in.
    do_reset();
    SLOW_OUT = 1'b1;
    for (int c = 0; c < WB; c++) wc(c, 3'b000, 4'h0, 1'b0);
    for (int c = 0; c <= 3; c++) wc(c, 3'b000, 4'b0101, 1'b0);
    chk("partial_oa", {12'h0, OA}, 16'h0005);
    rst = 1'b1;
    step();
    chk("reset_mid_dig", obs_all(), 16'h0000);
    rst = 1'b0;
    $display("sequence: reset during digit shift");

    // Unacknowledged offer held across three words, then SLOW_OUT drops.
    do_reset();
    SLOW_OUT = 1'b1;
    for (int c = 0; c <= 3; c++) wc(c, 3'b010, 4'h0, 1'b0);
    chk("cr_offer", {11'h0, CHAR_VALID, CHAR_IS_FMT, OF3, OF2, OF1},
        {11'h0, 1'b1, 1'b1, 3'b010});
    for (int g = 4; g < 4 + 3*WB; g++) begin
      wc(g % WB, 3'b111, 4'b1111, 1'b0);
      chk("hold_stable", {8'h0, CHAR_VALID, OF3, OF2, OF1, OA}, {8'h0, 1'b1, 3'b010, 4'h0});
    end
    SLOW_OUT = 1'b0;
    wc(5, 3'b000, 4'h0, 1'b0);
    chk("abort", {14'h0, CHAR_VALID, OUT_DONE}, 16'h0000);
    $display("sequence: held offer then abort");

    // Word marker mid-shift restarts the code load; ack outside the offer is ignored.
    do_reset();
    SLOW_OUT = 1'b1;
    for (int c = 0; c <= 2; c++) wc(c, 3'b111, 4'h0, 1'b1);
    for (int c = 0; c <= 2; c++) wc(c, 3'b010, 4'h0, 1'b1);
    chk("resync_mid", {15'h0, CHAR_VALID}, 16'h0000);
    wc(3, 3'b010, 4'h0, 1'b1);
    chk("resync_code", {12'h0, CHAR_VALID, OF3, OF2, OF1}, {12'h0, 1'b1, 3'b010});
    wc(4, 3'b010, 4'h0, 1'b0);
    chk("early_ack_ignored", {15'h0, CHAR_VALID}, 16'h0001);
    wc(5, 3'b010, 4'h0, 1'b1);
    chk("late_ack", {15'h0, CHAR_VALID}, 16'h0000);
    $display("sequence: mid-shift resync");

    plan(1'b1);
    run_plan(0);
    for (int r = 1; r <= 3; r++) begin
      plan(1'b0);
      run_plan(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
